quad_psum_drain: RTL and testbench

Collection end of the quad-MAC column: captures the four registered partial-sum outputs (w, x, y, z) that a quad-MAC column produces at the bottom of the systolic array. Buffers whole quads in a small FIFO and serializes them, one 32-bit lane per transfer, onto a valid/ready stream toward the output writer. Lane order is w, x, y, z. Dropped quads are flagged, never silently lost.

---
 rtl/quad_psum_drain_if.sv | 28 ++
 rtl/quad_psum_drain.sv | 109 ++++++++++
 tb/tb_quad_psum_drain.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_psum_drain_if.sv
// Stream bundle between the quad-MAC column, the drain block and the output writer.
// slave: drain-side view; master: producer/consumer (environment) view.
interface quad_psum_drain_if #(
  parameter int unsigned wxyzOutputBits = 32
);
  logic                      in_valid;
  logic [wxyzOutputBits-1:0] w;
  logic [wxyzOutputBits-1:0] x;
  logic [wxyzOutputBits-1:0] y;
  logic [wxyzOutputBits-1:0] z;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [wxyzOutputBits-1:0] out_data;
  logic [1:0]                out_lane;
  logic                      out_last;
  logic                      overflow;

  modport slave (
    input  in_valid, w, x, y, z, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, overflow
  );

  modport master (
    output in_valid, w, x, y, z, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, overflow
  );
endinterface

// File: rtl/quad_psum_drain.sv
// quad_psum_drain: buffers whole {w,x,y,z} partial-sum quads in a DEPTH-entry FIFO
// and serializes them one lane per transfer (w, x, y, z) onto a valid/ready stream.
// Quads offered while full are dropped and flagged in a sticky overflow bit.
// Optional build macro QUAD_DRAIN_RELU_EN: negative lane words are emitted as 0
// (FIFO contents untouched).
module quad_psum_drain #(
  parameter int unsigned wxyzOutputBits = 32,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  quad_psum_drain_if.slave     bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [wxyzOutputBits-1:0] r_mem [DEPTH][4];
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic [1:0]                r_lane;
  logic                      r_overflow;
  state_t                    r_state;

  state_t                    w_state_nxt;
  logic [CW-1:0]             w_count_nxt;
  logic                      w_in_ready;
  logic                      w_push;
  logic                      w_valid;
  logic                      w_fire;
  logic                      w_pop_last;
  logic [wxyzOutputBits-1:0] w_head;
  logic [wxyzOutputBits-1:0] w_lane_word;

  assign w_in_ready = (r_count != CW'(DEPTH));
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_valid    = (r_state == STREAM);
  assign w_fire     = w_valid && bus.out_ready;
  assign w_pop_last = w_fire && (r_lane == 2'd3);
  assign w_head     = r_mem[r_rptr][r_lane];

`ifdef QUAD_DRAIN_RELU_EN
  assign w_lane_word = w_head[wxyzOutputBits-1] ? '0 : w_head;
`else
  assign w_lane_word = w_head;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_lane_word : '0;
  assign bus.out_lane  = w_valid ? r_lane : '0;
  assign bus.out_last  = w_valid && (r_lane == 2'd3);
  assign bus.overflow  = r_overflow;

  // Quad storage: written on an accepted push, no reset needed (reads gated by valid)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr][0] <= bus.w;
      r_mem[r_wptr][1] <= bus.x;
      r_mem[r_wptr][2] <= bus.y;
      r_mem[r_wptr][3] <= bus.z;
    end
  end

  // Pointers, occupancy, lane counter, sticky overflow and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_lane     <= '0;
      r_overflow <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_fire) begin
        r_lane <= r_lane + 2'd1;
      end
      if (w_pop_last) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (bus.in_valid && !w_in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next occupancy and next FSM state; STREAM exactly while a quad is buffered
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (w_push && !w_pop_last) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop_last) begin
      w_count_nxt = r_count - 1'b1;
    end
    case (r_state)
      IDLE:    if (w_count_nxt != '0) w_state_nxt = STREAM;
      STREAM:  if (w_pop_last && (w_count_nxt == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_quad_psum_drain.sv
// Scoreboard bench for quad_psum_drain: stimulus pushes expected lanes into a queue,
// a negedge monitor pops and compares on every transfer. Honors QUAD_DRAIN_RELU_EN.
module tb_quad_psum_drain;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  quad_psum_drain_if #(.wxyzOutputBits(32)) bus ();

  quad_psum_drain #(.wxyzOutputBits(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] emit(input logic [31:0] v);
`ifdef QUAD_DRAIN_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_quad(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
    exp_q.push_back('{data: emit(a), lane: 2'd0, last: 1'b0});
    exp_q.push_back('{data: emit(b), lane: 2'd1, last: 1'b0});
    exp_q.push_back('{data: emit(c), lane: 2'd2, last: 1'b0});
    exp_q.push_back('{data: emit(d), lane: 2'd3, last: 1'b1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    bus.in_valid = v;
    bus.w = a;
    bus.x = b;
    bus.y = c;
    bus.z = d;
  endtask

  // Push a quad that the bench knows will be accepted on the coming edge
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    drive(1'b1, a, b, c, d);
    expect_quad(a, b, c, d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.out_ready = 1'b1;
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compares each transfer, zero outputs when idle, and stall stability
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_lane;
  logic        prev_last;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, prev_data);
          chk("stall_lane", bus.out_lane, prev_lane);
          chk("stall_last", bus.out_last, prev_last);
        end
        if (!bus.out_valid) begin
          chk("idle_zero", {bus.out_data, bus.out_lane, bus.out_last}, '0);
        end else if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer", bus.out_data, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_data", bus.out_data, e.data);
            chk("xfer_lane", bus.out_lane, e.lane);
            chk("xfer_last", bus.out_last, e.last);
          end
        end
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        prev_data  = bus.out_data;
        prev_lane  = bus.out_lane;
        prev_last  = bus.out_last;
      end
    end
  end

  initial begin
    int i;
    int cyc;
    logic [31:0] qv [4];

    drive(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_lane", bus.out_lane, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_overflow", bus.overflow, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single quad, latency and lane order
    bus.out_ready = 1'b1;
    push(32'd1, 32'hFFFF_FFFE, 32'd3, 32'h7FFF_FFFF);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_lane", bus.out_lane, 0);
    drain(20);

    // Fill with stalled output; 5th quad dropped
    bus.out_ready = 1'b0;
    push(32'h10, 32'h11, 32'h12, 32'h13);
    push(32'h20, 32'h21, 32'h22, 32'h23);
    push(32'h30, 32'h31, 32'h32, 32'h33);
    chk("pre_full_ready", bus.in_ready, 1);
    push(32'h40, 32'h41, 32'h42, 32'h43);
    chk("full_ready", bus.in_ready, 0);
    chk("pre_ovf", bus.overflow, 0);
    drive(1'b1, 32'h50, 32'h51, 32'h52, 32'h53);
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_set", bus.overflow, 1);
    repeat (3) tick();
    drain(40);
    chk("ovf_sticky", bus.overflow, 1);

    // Full FIFO: push on the lane-3 pop cycle refused, next cycle accepted
    do_reset();
    chk("ovf_cleared", bus.overflow, 0);
    bus.out_ready = 1'b0;
    push(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    push(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    push(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    push(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    drive(1'b1, 32'hEE, 32'hEE, 32'hEE, 32'hEE);
    chk("popcyc_ready", bus.in_ready, 0);
    tick();
    chk("popcyc_ovf", bus.overflow, 1);
    chk("after_pop_ready", bus.in_ready, 1);
    push(32'hF0, 32'hF1, 32'h8000_0000, 32'hF3);
    drain(40);

    // Reset mid-quad at lane 2 (overflow is high going in)
    bus.out_ready = 1'b0;
    push(32'h100, 32'h101, 32'h102, 32'h103);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("mid_lane2", bus.out_lane, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", bus.out_valid, 0);
    chk("async_ovf", bus.overflow, 0);
    chk("async_data", bus.out_data, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("post_rst_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    push(32'h200, 32'h201, 32'h202, 32'h203);
    drain(20);

    // Half-full: simultaneous push and lane-3 pop keeps count
    bus.out_ready = 1'b0;
    push(32'h300, 32'h301, 32'h302, 32'h303);
    push(32'h310, 32'h311, 32'h312, 32'h313);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    push(32'h320, 32'h321, 32'h322, 32'h323);
    bus.out_ready = 1'b0;
    push(32'h330, 32'h331, 32'h332, 32'h333);
    chk("hf_ready3", bus.in_ready, 1);
    push(32'h340, 32'h341, 32'h342, 32'h343);
    chk("hf_ready4", bus.in_ready, 0);
    drain(40);

    // 100 quads with ~30% out_ready
    i = 0;
    cyc = 0;
    while (i < 100 && cyc < 5000) begin
      bus.out_ready = ($urandom_range(0, 9) < 3);
      if (bus.in_ready) begin
        qv[0] = $urandom;
        qv[1] = $urandom;
        qv[2] = 32'(i);
        qv[3] = ~32'(i);
        drive(1'b1, qv[0], qv[1], qv[2], qv[3]);
        expect_quad(qv[0], qv[1], qv[2], qv[3]);
        i++;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("rand_issued", i, 100);
    for (int k = 0; k < 5000 && exp_q.size() != 0; k++) begin
      bus.out_ready = ($urandom_range(0, 9) < 3);
      tick();
    end
    drain(40);
    chk("rand_ovf", bus.overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
